// File: rtl/ps2_kbd_pkg.sv
// Shared constants, state encoding and key lookup for the PS/2 key controller.
// Scan codes are PS/2 Set 2.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_AA    = 8'hAA;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_SPACE = 3'd4;
    localparam logic [2:0] KEY_ENTER = 3'd5;
    localparam logic [2:0] KEY_ESC   = 3'd6;
    localparam logic [2:0] KEY_P     = 3'd7;

    localparam int         EV_W      = 4;
    localparam int         EV_MAKE   = 3;
    localparam int         EV_IDX_HI = 2;
    localparam logic [2:0] SKIP_LEN  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Plain 75/72/6B/74 are keypad keys and deliberately miss.
    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r = '0;
        if (ext) begin
            case (code)
                SC_UP:    r = '{1'b1, KEY_UP};
                SC_DOWN:  r = '{1'b1, KEY_DOWN};
                SC_LEFT:  r = '{1'b1, KEY_LEFT};
                SC_RIGHT: r = '{1'b1, KEY_RIGHT};
                default:  r = '0;
            endcase
        end else begin
            case (code)
                SC_SPACE: r = '{1'b1, KEY_SPACE};
                SC_ENTER: r = '{1'b1, KEY_ENTER};
                SC_ESC:   r = '{1'b1, KEY_ESC};
                SC_P:     r = '{1'b1, KEY_P};
                default:  r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous event FIFO with a registered head and a flush.
// Push and pop in the same cycle both take effect, even when full.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_rd;
    logic [AW:0]  r_wr;
    logic [W-1:0] r_head;
    logic         w_do_pop;
    logic         w_do_push;
    logic [AW:0]  w_rd_nxt;
    logic [AW:0]  w_wr_nxt;

    assign empty     = (r_rd == r_wr);
    assign full      = (r_rd[AW] != r_wr[AW]) && (r_rd[AW-1:0] == r_wr[AW-1:0]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign w_rd_nxt  = r_rd + {{AW{1'b0}}, w_do_pop};
    assign w_wr_nxt  = r_wr + {{AW{1'b0}}, w_do_push};
    assign head      = r_head;

    always_ff @(posedge clk) begin
        if (w_do_push && !flush)
            r_mem[r_wr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_head <= '0;
        end else if (flush) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_head <= '0;
        end else begin
            r_rd <= w_rd_nxt;
            r_wr <= w_wr_nxt;
            // The entry just written becomes head when it lands at the new read slot.
            if (w_do_push && (w_rd_nxt == r_wr))
                r_head <= din;
            else if (w_rd_nxt != r_wr)
                r_head <= r_mem[w_rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 Set-2 prefix decoder: tracks eight game-key levels and queues
// deduplicated make/break events for the game logic.
module ps2_key_controller
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    input  logic            rx_err,
    input  logic            ovf_clr,
    output logic [7:0]      key_state,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_data,
    input  logic            ev_ready,
    output logic            ev_ovf,
    output logic            busy
);
    localparam int            CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    logic [2:0]      r_skip;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_keys;
    logic            r_ovf;

    logic            w_byte;
    logic            w_ext;
    logic            w_brk;
    logic            w_code;
    logic            w_push;
    logic            w_flush;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic [EV_W-1:0] w_ev;
    key_hit_t        w_hit;

    assign w_byte = rx_valid & ~rx_err;
    assign w_ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    assign w_brk  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
    assign w_hit  = key_lookup(w_ext, rx_data);

    // Does this byte complete a code (as opposed to a prefix or skipped byte)?
    always_comb begin
        w_code = 1'b0;
        unique case (1'b1)
            r_state == ST_IDLE:
                w_code = !(rx_data inside {SC_E0, SC_F0, SC_E1, SC_AA});
            r_state == ST_EXT:
                w_code = (rx_data != SC_F0);
            w_brk:
                w_code = 1'b1;
            default:
                w_code = 1'b0;
        endcase
    end

    assign w_push  = w_byte & w_code & w_hit.hit
                   & (w_brk ? r_keys[w_hit.idx] : ~r_keys[w_hit.idx]);
    assign w_ev    = {~w_brk, w_hit.idx};
    assign w_flush = w_byte & (r_state == ST_IDLE) & (rx_data == SC_AA);
    assign w_drop  = w_push & w_full & ~(ev_ready & ~w_empty);

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (w_push),
        .pop   (ev_ready),
        .flush (w_flush),
        .din   (w_ev),
        .full  (w_full),
        .empty (w_empty),
        .head  (ev_data)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_keys <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_flush)
                r_keys <= '0;
            else if (w_push)
                r_keys[w_hit.idx] <= ~w_brk;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
            r_cnt   <= '0;
        end else if (rx_err) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
            r_cnt   <= '0;
        end else if (rx_valid) begin
            r_cnt <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == SC_E0)
                        r_state <= ST_EXT;
                    else if (rx_data == SC_F0)
                        r_state <= ST_BRK;
                    else if (rx_data == SC_E1) begin
                        r_state <= ST_SKIP;
                        r_skip  <= SKIP_LEN;
                    end
                end
                ST_EXT:
                    r_state <= (rx_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
                ST_SKIP: begin
                    if (r_skip == 3'd1)
                        r_state <= ST_IDLE;
                    r_skip <= r_skip - 3'd1;
                end
                default:
                    r_state <= ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_cnt == TO_LAST) begin
                r_state <= ST_IDLE;
                r_skip  <= '0;
                r_cnt   <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign key_state = r_keys;
    assign ev_valid  = ~w_empty;
    assign ev_ovf    = r_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller: expected events are queued as
// bytes are sent and compared as the DUT pops them.
module tb_ps2_key_controller;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] key_state;
    logic       ev_valid;
    logic [3:0] ev_data;
    logic       ev_ready = 1'b0;
    logic       ev_ovf;
    logic       busy;

    logic [3:0] exp_q[$];
    int         errs = 0;
    int         checks = 0;

    ps2_key_controller #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .ovf_clr   (ovf_clr),
        .key_state (key_state),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ev_ready  (ev_ready),
        .ev_ovf    (ev_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // A pop happens at the next posedge whenever ev_valid & ev_ready here.
    always @(negedge clk) begin
        if (!clr && ev_valid && ev_ready) begin
            if (exp_q.size() == 0)
                check("spurious_ev", ev_valid, 0);
            else
                check("ev_data", ev_data, exp_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            @(posedge clk);
        check({tag, "_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
        check({tag, "_empty"}, ev_valid, 0);
    endtask

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_keys", key_state, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_data", ev_data, 0);
        check("rst_ovf", ev_ovf, 0);
        check("rst_busy", busy, 0);
        clr = 1'b0;
        ev_ready = 1'b1;

        // Keypad 75 is not a game key; extended 75 is up.
        send(8'h75);
        check("kp75_keys", key_state, 0);
        check("kp75_valid", ev_valid, 0);
        send(8'hE0);
        exp_q.push_back(4'b1_000);
        send(8'h75);
        check("up_latency", ev_valid, 1);
        check("up_keys", key_state, 8'h01);
        drain("up_make");
        send(8'hE0);
        send(8'hF0);
        exp_q.push_back(4'b0_000);
        send(8'h75);
        check("up_brk_keys", key_state, 0);
        drain("up_brk");

        // Typematic repeats are suppressed.
        exp_q.push_back(4'b1_100);
        send(8'h29);
        send(8'h29);
        send(8'h29);
        check("typ_keys", key_state, 8'h10);
        send(8'hF0);
        exp_q.push_back(4'b0_100);
        send(8'h29);
        drain("typ");
        check("typ_rel_keys", key_state, 0);

        // Fill the FIFO, drop the fifth event.
        ev_ready = 1'b0;
        exp_q.push_back(4'hC);
        send(8'h29);
        exp_q.push_back(4'hD);
        send(8'h5A);
        exp_q.push_back(4'hE);
        send(8'h76);
        exp_q.push_back(4'hF);
        send(8'h4D);
        check("full_no_ovf", ev_ovf, 0);
        send(8'hE0);
        send(8'h6B);
        check("ovf_set", ev_ovf, 1);
        check("ovf_keys", key_state, 8'hF4);
        check("head_hold", ev_data, 4'hC);
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        check("ovf_clr", ev_ovf, 0);
        ev_ready = 1'b1;
        drain("ovf");
        exp_q.push_back(4'h4);
        send(8'hF0); send(8'h29);
        exp_q.push_back(4'h5);
        send(8'hF0); send(8'h5A);
        exp_q.push_back(4'h6);
        send(8'hF0); send(8'h76);
        exp_q.push_back(4'h7);
        send(8'hF0); send(8'h4D);
        exp_q.push_back(4'b0_010);
        send(8'hE0); send(8'hF0); send(8'h6B);
        drain("rel_all");
        check("rel_all_keys", key_state, 0);

        // Pause sequence is swallowed.
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            check($sformatf("pause_busy%0d", i), busy, (i < 7) ? 1 : 0);
        end
        check("pause_keys", key_state, 0);
        check("pause_valid", ev_valid, 0);

        // Abandoned E0 prefix.
        send(8'hE0);
        repeat (TO - 2) @(posedge clk);
        #1;
        check("to_busy_before", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        check("to_busy_after", busy, 0);
        send(8'h75);
        check("to_75_keys", key_state, 0);
        check("to_75_valid", ev_valid, 0);

        // Error aborts a prefix.
        exp_q.push_back(4'b1_000);
        send(8'hE0); send(8'h75);
        drain("up2");
        send(8'hE0, 1'b1);
        check("err_idle", busy, 0);
        send(8'hF0); send(8'h75);
        check("err_up_held", key_state, 8'h01);
        check("err_valid", ev_valid, 0);

        // BAT flush beats a simultaneous pop.
        ev_ready = 1'b0;
        exp_q.push_back(4'hC);
        send(8'h29);
        exp_q.push_back(4'hD);
        send(8'h5A);
        check("pre_aa_keys", key_state, 8'h31);
        @(posedge clk); #1;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        ev_ready = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        exp_q.delete();
        check("aa_keys", key_state, 0);
        check("aa_valid", ev_valid, 0);

        // Async clear mid-sequence.
        exp_q.push_back(4'hC);
        send(8'h29);
        drain("sp3");
        send(8'hF0);
        check("brk_busy", busy, 1);
        #2;
        clr = 1'b1;
        #1;
        check("clr_keys", key_state, 0);
        check("clr_valid", ev_valid, 0);
        check("clr_data", ev_data, 0);
        check("clr_ovf", ev_ovf, 0);
        check("clr_busy", busy, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check("end_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Scan-code sequencer between the PS/2 byte receiver and the game logic. It consumes a stream of received keyboard bytes and runs the PS/2 Set-2 prefix state machine (E0 extended, F0 break, E1 pause). It maintains level flags for the eight game keys and queues deduplicated press/release events in a small FIFO with a valid/ready handshake. Game-control and menu logic read key levels and events from this block, never raw scan codes.

## Interface
- TIMEOUT_CYCLES, 2_500_000, idle cycles after a prefix byte before the sequence is abandoned (50 ms at 50 MHz)
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- rx_data  in  8  received scan-code byte
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- rx_err  in  1  one-cycle strobe; framing/parity error on current byte
- ovf_clr  in  1  clears ev_ovf
- key_state  out  8  level per key, 1 = held; index order: 0 up, 1 down, 2 left, 3 right, 4 space, 5 enter, 6 esc, 7 P
- ev_valid  out  1  FIFO head holds an event
- ev_data  out  4  {make(1)/break(0), key index[2:0]}
- ev_ready  in  1  consumer pops the head when ev_valid & ev_ready
- ev_ovf  out  1  sticky; an event was dropped
- busy  out  1  a multi-byte sequence is in progress (state ≠ IDLE)

## Operation
- States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (after E1).
- IDLE: E0→EXT; F0→BRK; E1→SKIP, skip count = 7; AA (BAT pass)→clear key_state, flush FIFO; any other byte is a make of a plain code.
- EXT: F0→EXT_BRK; other byte → extended make, →IDLE.
- BRK → plain break, →IDLE. EXT_BRK → extended break, →IDLE.
- SKIP: decrement per byte; →IDLE after the 7th byte. No key effect.
- Key map. Plain: 29 space, 5A enter, 76 esc, 4D P. Extended: 75 up, 72 down, 6B left, 74 right. All other codes are consumed with no effect, including plain 75/72/6B/74 (keypad).
- Make of a key not held: set flag, push {1,idx}. Make of a key already held (typematic) sets nothing and pushes nothing.
- Break of a held key: clear flag, push {0,idx}. Break of a key not held: no effect.
- rx_err: byte is ignored and state→IDLE. The skip count and the timeout counter are cleared. key_state is unchanged.
- Timeout: in any non-IDLE state, a counter counts cycles without rx_valid. At TIMEOUT_CYCLES−1 the block goes to IDLE. Any rx_valid reloads the counter to 0.
- FIFO is FIFO_DEPTH deep. A push when full with no simultaneous pop drops the new event and sets ev_ovf. ev_ovf clears only on ovf_clr or clr. ovf_clr and a new overflow in the same cycle leave ev_ovf = 1.
- Simultaneous push and pop: both happen, including when full. The count is unchanged.
- AA flush and an ev_ready pop in the same cycle: the flush wins and the FIFO is empty.

## Timing
- Reset values: key_state = 0, ev_valid = 0, ev_data = 0, ev_ovf = 0, busy = 0. State IDLE, counters 0, FIFO empty.
- clr is asynchronous and may assert mid-sequence. All state returns to reset values immediately.
- A byte presented with rx_valid at edge N updates the state, key_state and the FIFO write at edge N. These are visible after edge N.
- Event latency: when the FIFO is empty, ev_valid is high the cycle after the rx_valid cycle. ev_data is the FIFO head, registered.
- A pop at edge M shows the next entry (or ev_valid = 0) after edge M. ev_data is held stable while ev_valid & !ev_ready.
- rx_valid and rx_err together: the error wins.
- rx_valid may arrive every cycle. No back-pressure to the receiver.
- Counter width: ceil(log2(TIMEOUT_CYCLES)) bits, saturating (no wrap). FIFO pointers: log2(FIFO_DEPTH) bits plus a wrap bit.

## Structure
- Package ps2_kbd_pkg holds:
  - scan-code constants (E0, E1, F0, AA and the eight key codes);
  - key index constants;
  - the state encoding;
  - the event field positions.
- One sub-module, ps2_event_fifo: a synchronous FIFO with parameterised depth and width 4. It has push, pop, flush, full, empty and a registered head.
- The decoder FSM, key map, key_state register and timeout counter stay in the top level.

## Test plan
- 75 alone (no E0) → key_state = 0, no event. Then E0 75 → key_state = 8'h01, ev_data = 4'b1_000. Then E0 F0 75 → key_state = 0, ev_data = 4'b0_000.
- 29, 29, 29 (typematic), then F0 29 → exactly two events, {1,100} and {0,100}. key_state[4] is high between them.
- ev_ready = 0, five makes (space, enter, esc, P, then E0 6B): the first four are queued, the fifth is dropped, ev_ovf = 1. key_state = 8'hF4 (left set despite the drop). ovf_clr → ev_ovf = 0.
- E1 14 77 E1 F0 14 F0 77 → busy high for 8 bytes, no events, key_state unchanged. busy = 0 after the last byte.
- E0 then TIMEOUT_CYCLES idle cycles, then 75 → busy falls at the timeout. The 75 is treated as a plain code, so no event.
- Up held, E0 with rx_err, then F0 75 → state stays IDLE after the error and up stays held. Then AA → key_state = 0, FIFO empty. Assert clr while in BRK → all outputs 0 immediately.
